// File: rtl/alu_regfile_seq_if.sv
// Command/host bus for alu_regfile_seq: register writes, command handshake
// and result/status return. The host drives the master side and the ALU the slave side.
interface alu_regfile_seq_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       opcode;
  logic [AW-1:0]    src_a;
  logic [AW-1:0]    src_b;
  logic [AW-1:0]    dst;
  logic             res_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             res_err;
  logic             busy;

  modport master (
    output wr_en, wr_addr, wr_data, op_valid, opcode, src_a, src_b, dst,
    input  op_ready, res_valid, result, flags, res_err, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, op_valid, opcode, src_a, src_b, dst,
    output op_ready, res_valid, result, flags, res_err, busy
  );
endinterface

// File: rtl/alu_regfile_seq.sv
// Sequential ALU with an NREGS-entry register file, a valid/ready command
// port, bit-serial shifts and registered result/flags with writeback.
// Optional macro ALU_SEQ_MUL_EN enables opcode 7 as a shift-add multiply;
// without it opcode 7 completes immediately with res_err set.
module alu_regfile_seq #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  alu_regfile_seq_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_SEQ_MUL_EN
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [1:0] S_MUL = 2'd2;
`else
  localparam int ACC_W = WIDTH;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [WIDTH-1:0] regs [NREGS];
  logic [1:0]       state;
  logic [CW-1:0]    cnt_p1;
  logic [ACC_W-1:0] acc_p1;
  logic             shl_p1;
  logic [AW-1:0]    dst_p1;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_p1;
  logic [WIDTH:0]   psum;
`endif
  logic [WIDTH-1:0] result_p2;
  logic [3:0]       flags_p2;
  logic             vld_p2;
  logic             err_p2;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [SW-1:0]    amt;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [ACC_W-1:0] step_acc;
  logic             step_c;
  logic             done;
  logic             err;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [3:0]       wb_flags;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {(r == '0), r[WIDTH-1], c, v};
  endfunction

  // Two's-complement overflow of a +/- b, from a sign-extended result.
  function automatic logic ovf(input logic signed [WIDTH-1:0] a,
                               input logic signed [WIDTH-1:0] b,
                               input logic sub);
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    logic signed [WIDTH:0] s;
    ea = a;
    eb = b;
    s  = sub ? (ea - eb) : (ea + eb);
    return s[WIDTH] ^ s[WIDTH-1];
  endfunction

  assign opa    = regs[bus.src_a];
  assign opb    = regs[bus.src_b];
  assign amt    = opb[SW-1:0];
  assign accept = (state == S_IDLE) && bus.op_valid && ena;
  assign sum    = {1'b0, opa} + {1'b0, opb};
  assign diff   = {1'b0, opa} - {1'b0, opb};

  // One bit-serial step of the operation in flight
  always_comb begin
    step_acc = acc_p1;
    step_c   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    psum     = '0;
`endif
    if (state == S_SHIFT) begin
      if (shl_p1) begin
        step_c                = acc_p1[WIDTH-1];
        step_acc[WIDTH-1:0]   = {acc_p1[WIDTH-2:0], 1'b0};
      end else begin
        step_c                = acc_p1[0];
        step_acc[WIDTH-1:0]   = {1'b0, acc_p1[WIDTH-1:1]};
      end
    end
`ifdef ALU_SEQ_MUL_EN
    else if (state == S_MUL) begin
      // Product sits in {hi, lo}; lo starts as B and is consumed LSB first.
      psum     = {1'b0, acc_p1[ACC_W-1:WIDTH]} + (acc_p1[0] ? {1'b0, mcand_p1} : '0);
      step_acc = {psum, acc_p1[WIDTH-1:1]};
      step_c   = |step_acc[ACC_W-1:WIDTH];
    end
`endif
  end

  // Completion decode: single-cycle ops finish at the accept edge,
  // serial ops on the edge that consumes their last count
  always_comb begin
    done     = 1'b0;
    err      = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = dst_p1;
    wb_data  = '0;
    wb_flags = '0;
    if (accept) begin
      wb_addr = bus.dst;
      case (bus.opcode)
        OP_ADD: begin
          done = 1'b1; wb_en = 1'b1; wb_data = sum[WIDTH-1:0];
          wb_flags = mk_flags(sum[WIDTH-1:0], sum[WIDTH], ovf(opa, opb, 1'b0));
        end
        OP_SUB: begin
          done = 1'b1; wb_en = 1'b1; wb_data = diff[WIDTH-1:0];
          wb_flags = mk_flags(diff[WIDTH-1:0], ~diff[WIDTH], ovf(opa, opb, 1'b1));
        end
        OP_AND: begin
          done = 1'b1; wb_en = 1'b1; wb_data = opa & opb;
          wb_flags = mk_flags(opa & opb, 1'b0, 1'b0);
        end
        OP_OR: begin
          done = 1'b1; wb_en = 1'b1; wb_data = opa | opb;
          wb_flags = mk_flags(opa | opb, 1'b0, 1'b0);
        end
        OP_XOR: begin
          done = 1'b1; wb_en = 1'b1; wb_data = opa ^ opb;
          wb_flags = mk_flags(opa ^ opb, 1'b0, 1'b0);
        end
        OP_SHL, OP_SHR: begin
          if (amt == '0) begin
            done = 1'b1; wb_en = 1'b1; wb_data = opa;
            wb_flags = mk_flags(opa, 1'b0, 1'b0);
          end
        end
        default: begin
`ifndef ALU_SEQ_MUL_EN
          done = 1'b1;
          err  = 1'b1;
`endif
        end
      endcase
    end else if ((state != S_IDLE) && ena && (cnt_p1 == CW'(1))) begin
      done     = 1'b1;
      wb_en    = 1'b1;
      wb_data  = step_acc[WIDTH-1:0];
      wb_flags = mk_flags(step_acc[WIDTH-1:0], step_c, 1'b0);
    end
  end

  // Register file: host write first, writeback last so it wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (ena) begin
      if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
      if (wb_en) regs[wb_addr] <= wb_data;
    end
  end

  // Control FSM, result/flag registers and the completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt_p1    <= '0;
      vld_p2    <= 1'b0;
      err_p2    <= 1'b0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else if (!ena) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= done;
      err_p2 <= err;
      if (wb_en) begin
        result_p2 <= wb_data;
        flags_p2  <= wb_flags;
      end
      if (state == S_IDLE) begin
        if (accept && (bus.opcode == OP_SHL || bus.opcode == OP_SHR) && amt != '0) begin
          state  <= S_SHIFT;
          cnt_p1 <= CW'(amt);
        end
`ifdef ALU_SEQ_MUL_EN
        else if (accept && bus.opcode == OP_MUL) begin
          state  <= S_MUL;
          cnt_p1 <= CW'(WIDTH);
        end
`endif
      end else begin
        cnt_p1 <= cnt_p1 - CW'(1);
        if (cnt_p1 == CW'(1)) state <= S_IDLE;
      end
    end
  end

  // Operand snapshot at accept, then one serial step per enabled cycle
  always_ff @(posedge clk) begin
    if (ena) begin
      if (accept) begin
        acc_p1 <= ACC_W'(opa);
        shl_p1 <= (bus.opcode == OP_SHL);
        dst_p1 <= bus.dst;
`ifdef ALU_SEQ_MUL_EN
        if (bus.opcode == OP_MUL) acc_p1 <= ACC_W'(opb);
        mcand_p1 <= opa;
`endif
      end else if (state != S_IDLE) begin
        acc_p1 <= step_acc;
      end
    end
  end

  assign bus.op_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.res_valid = vld_p2;
  assign bus.result    = result_p2;
  assign bus.flags     = flags_p2;
  assign bus.res_err   = err_p2;
endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
- Parametrised successor to the 8-bit two-register ALU.
- Generalised in data width and in operand storage: a NREGS-entry register file replaces the fixed A/B pair.
- Adds a valid/ready command handshake, multi-cycle shifts (one bit per cycle), registered flags and result writeback.
- Sits between the pin-level wrapper (switch/LED mapping) and the host that loads operands and issues commands.

Parameters:
- WIDTH, 8, datapath width in bits (>=4)
- NREGS, 4, register-file depth (power of 2, >=2)
- AW, $clog2(NREGS), register address width (derived; do not override)
- SW, $clog2(WIDTH), shift-amount width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ena  in  1  global enable; low freezes all state
- wr_en  in  1  host register write strobe
- wr_addr  in  AW  host write address
- wr_data  in  WIDTH  host write data
- op_valid  in  1  command valid
- op_ready  out  1  block can accept a command
- opcode  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
- src_a  in  AW  operand A register index
- src_b  in  AW  operand B register index
- dst  in  AW  result register index
- res_valid  out  1  one-cycle pulse: result/flags updated
- result  out  WIDTH  last result (held)
- flags  out  4  {Z,N,C,V} of last result (held)
- res_err  out  1  qualifies res_valid: illegal opcode
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (rst=1 at clk edge, overrides ena):
  - all registers 0; state IDLE
  - outputs after reset: op_ready=1, res_valid=0, result=0, flags=0, res_err=0, busy=0
- ena=0: no state, register, counter or output change; res_valid holds 0; host writes are dropped.
- States:
  - IDLE: op_ready=1. Accept on op_valid&&op_ready&&ena (cycle T); capture regs[src_a], regs[src_b], opcode, dst.
  - ALU (single cycle): ADD/SUB/AND/OR/XOR, and SHL/SHR with amount 0. Completes at edge T+1; res_valid=1 during cycle T+1; back to IDLE.
  - SHIFT: amount = B[SW-1:0]. One bit per enabled cycle; busy=1, op_ready=0. Completes amount cycles after entry: res_valid at T+1+amount.
  - MUL: see Optional Feature.
- Writeback: at completion result -> regs[dst], result and flags outputs updated together.
- Host write and writeback to the same address in the same cycle: writeback wins. Host writes to other addresses always proceed, including while busy.
- Operands are snapshotted at accept; later host writes do not affect an op in flight.
- Flags:
  - Z = (result==0); N = result[WIDTH-1]
  - ADD: C = carry out; V = signed overflow
  - SUB (A-B): C = 1 when no borrow (A>=B unsigned); V = signed overflow
  - Logic ops: C=0, V=0
  - SHL/SHR (logical, zero fill): C = last bit shifted out (0 if amount 0); V=0
- op_ready is combinational from state only (IDLE); never depends on op_valid.
- A new command may be accepted in the same cycle res_valid is high (back-to-back single-cycle ops at one per cycle).
- rst mid-operation: op aborted, no writeback, no res_valid.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined:
  - opcode 7 is an unsigned shift-add multiply, one bit of B per cycle, WIDTH cycles in state MUL; res_valid at T+1+WIDTH.
  - result = low WIDTH bits of A*B; C = (high half != 0); V=0; Z/N from the low half.
- Undefined:
  - opcode 7 is illegal: completes at T+1 with res_valid=1, res_err=1.
  - result and flags outputs unchanged; no writeback.
- res_err=0 for every other completion.

Test Plan (WIDTH=8, NREGS=4):
- Reset then load r0=0x7F, r1=0x01 -> ADD a=0,b=1,dst=2 -> res_valid at T+1; result=0x80, flags Z0 N1 C0 V1; r2=0x80.
- r0=0x05, r1=0x05, SUB dst=3 -> result=0x00, Z1 N0 C1 V0; then SUB a=1(0x05), b=2(0x80) -> result=0x85, C0.
- r0=0x81, r1=0x03, SHL dst=0 -> busy 3 cycles, op_ready=0; res_valid at T+4; result=0x08, C=0. Repeat with r1=0x01 -> result=0x02, C=1. Drop ena for 2 cycles mid-shift -> completion slips exactly 2 cycles.
- Host wr_en to dst in the completion cycle of an AND -> register holds the ALU result. Host write to src_a during an in-flight shift -> result unaffected.
- With ALU_SEQ_MUL_EN: 0x10*0x11 -> res_valid at T+9; result=0x10, C=1. Without it: opcode 7 -> res_err=1 at T+1, result/flags unchanged.
- Assert rst during SHIFT -> next cycle op_ready=1, busy=0, all regs 0, no res_valid pulse.
